// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver (LSB first, idle-high line).
// Synchronises rx_in, qualifies the start bit at mid-bit, samples each data
// bit at mid-bit and checks the stop bit. A good frame updates rxdata_out
// with a one-cycle rx_valid_out pulse. A low stop bit gives a one-cycle
// frame_err_out pulse instead.
module uart_rx #(
  parameter int CLK_RATE_MHz      = 100,
  parameter int DATA_WIDTH        = 8,
  parameter int CLK_COUNTER_WIDTH = 14,
  parameter int COUNTER_REG_WIDTH = 4,
  parameter int CLK_COUNTER_INV   = 10416,
  parameter int BOUDRATE          = 9600
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rxdata_out,
  output logic                  rx_valid_out,
  output logic                  frame_err_out,
  output logic                  busy_out
);

  // Bit period P = CLK_COUNTER_INV+1 clocks; the start bit is qualified H = P/2 clocks after the edge.
  localparam int BIT_PERIOD = CLK_COUNTER_INV + 1;
  localparam int HALF_BIT   = BIT_PERIOD / 2;

  localparam logic [CLK_COUNTER_WIDTH:0] CNT_LAST = (CLK_COUNTER_WIDTH+1)'(CLK_COUNTER_INV);
  localparam logic [CLK_COUNTER_WIDTH:0] CNT_HALF = (CLK_COUNTER_WIDTH+1)'(HALF_BIT - 1);
  localparam logic [COUNTER_REG_WIDTH:0] BIT_LAST = (COUNTER_REG_WIDTH+1)'(DATA_WIDTH - 1);

  // Reject parameter sets the timing logic cannot represent.
  if (CLK_COUNTER_INV < 2 || CLK_COUNTER_INV >= (2 ** (CLK_COUNTER_WIDTH + 1)) ||
      DATA_WIDTH < 1 || DATA_WIDTH >= (2 ** (COUNTER_REG_WIDTH + 1)) ||
      CLK_RATE_MHz <= 0 || BOUDRATE <= 0) begin : g_bad_params
    $error("uart_rx: inconsistent timing or width parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                       state;
  logic [CLK_COUNTER_WIDTH:0]   clk_counter;
  logic [COUNTER_REG_WIDTH:0]   bit_idx;
  logic [DATA_WIDTH-1:0]        shift_q;
  logic                         rx_meta;
  logic                         rx_s;
  logic                         rx_s_d;

  // Two-flop synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // Frame FSM with registered data, pulse and busy outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      clk_counter   <= '0;
      bit_idx       <= '0;
      shift_q       <= '0;
      rxdata_out    <= '0;
      rx_valid_out  <= 1'b0;
      frame_err_out <= 1'b0;
      busy_out      <= 1'b0;
    end else begin
      rx_valid_out  <= 1'b0;
      frame_err_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s && rx_s_d) begin
            state       <= START;
            clk_counter <= '0;
            busy_out    <= 1'b1;
          end
        end
        START: begin
          if (clk_counter == CNT_HALF) begin
            clk_counter <= '0;
            if (rx_s) begin
              state    <= IDLE;
              busy_out <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            clk_counter <= clk_counter + 1'b1;
          end
        end
        DATA: begin
          if (clk_counter == CNT_LAST) begin
            // LSB arrives first, so shifting in from the top leaves bit i at position i after DATA_WIDTH bits.
            shift_q     <= {rx_s, shift_q[DATA_WIDTH-1:1]};
            clk_counter <= '0;
            bit_idx     <= bit_idx + 1'b1;
            if (bit_idx == BIT_LAST) begin
              state <= STOP;
            end
          end else begin
            clk_counter <= clk_counter + 1'b1;
          end
        end
        STOP: begin
          if (clk_counter == CNT_LAST) begin
            // Leave at mid-stop-bit so a back-to-back start edge is not missed.
            state       <= IDLE;
            clk_counter <= '0;
            busy_out    <= 1'b0;
            if (rx_s) begin
              rxdata_out   <= shift_q;
              rx_valid_out <= 1'b1;
            end else begin
              frame_err_out <= 1'b1;
            end
          end else begin
            clk_counter <= clk_counter + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames on rx_in, compared every cycle
// against a frame-timing reference model, plus literal end-of-test values.
module tb_uart_rx;

  localparam int INV = 99;
  localparam int P   = INV + 1;
  localparam int H   = P / 2;
  localparam int DW  = 8;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          rx_in  = 1'b1;
  logic [DW-1:0] rxdata_out;
  logic          rx_valid_out;
  logic          frame_err_out;
  logic          busy_out;

  int checks   = 0;
  int failures = 0;

  uart_rx #(
    .CLK_RATE_MHz     (100),
    .DATA_WIDTH       (DW),
    .CLK_COUNTER_WIDTH(14),
    .COUNTER_REG_WIDTH(4),
    .CLK_COUNTER_INV  (INV),
    .BOUDRATE         (9600)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rx_in        (rx_in),
    .rxdata_out   (rxdata_out),
    .rx_valid_out (rx_valid_out),
    .frame_err_out(frame_err_out),
    .busy_out     (busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: line value seen by the receiver is rx_in delayed through the
  // synchroniser; frame events are placed by arithmetic on the start-edge cycle t0.
  int            cyc = 0;
  int            t0  = 0;
  int            rel;
  int            nbit;
  bit            m_ok = 0;
  bit            in_frame = 0;
  logic          m_s1 = 1'b1, m_s2 = 1'b1, m_s2d = 1'b1;
  logic          rs, rsd;
  logic [DW-1:0] word = '0;
  logic [DW-1:0] e_data = '0;
  logic          e_valid = 1'b0, e_ferr = 1'b0, e_busy = 1'b0;

  always @(posedge clk_in) begin
    rs  = m_s2;
    rsd = m_s2d;
    if (rst_in) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_s2d = 1'b1;
      in_frame = 0;
      e_data = '0; e_valid = 1'b0; e_ferr = 1'b0; e_busy = 1'b0;
      m_ok = 1;
    end else begin
      e_valid = 1'b0;
      e_ferr  = 1'b0;
      if (!in_frame) begin
        if (rs == 1'b0 && rsd == 1'b1) begin
          in_frame = 1;
          t0       = cyc;
          e_busy   = 1'b1;
        end
      end else begin
        rel = cyc - t0;
        if (rel == H) begin
          if (rs) begin
            in_frame = 0;
            e_busy   = 1'b0;
          end
        end else if (rel > H && (rel - H) % P == 0) begin
          nbit = (rel - H) / P;
          if (nbit <= DW) begin
            word[nbit-1] = rs;
          end else begin
            in_frame = 0;
            e_busy   = 1'b0;
            if (rs) begin
              e_data  = word;
              e_valid = 1'b1;
            end else begin
              e_ferr = 1'b1;
            end
          end
        end
      end
      m_s2d = m_s2;
      m_s2  = m_s1;
      m_s1  = rx_in;
    end
    cyc++;
  end

  // Observed pulse log for the literal end-of-test checks.
  int            n_valid = 0;
  int            n_ferr  = 0;
  logic [DW-1:0] got_q[$];

  always @(negedge clk_in) begin
    if (m_ok) begin
      chk("rx_valid_out",  {31'd0, rx_valid_out},  {31'd0, e_valid});
      chk("frame_err_out", {31'd0, frame_err_out}, {31'd0, e_ferr});
      chk("busy_out",      {31'd0, busy_out},      {31'd0, e_busy});
      chk("rxdata_out",    {24'd0, rxdata_out},    {24'd0, e_data});
      if (rx_valid_out === 1'b1) begin
        n_valid++;
        got_q.push_back(rxdata_out);
      end
      if (frame_err_out === 1'b1) n_ferr++;
    end
  end

  // Callers arrive just after a posedge; the level is held for n clocks.
  task automatic hold(input logic v, input int n);
    rx_in = v;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input int per);
    hold(1'b0, per);
    for (int i = 0; i < DW; i++) hold(d[i], per);
    hold(stop, per);
  endtask

  task automatic pulse_reset();
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  logic [DW-1:0] rd;
  logic          rstop;
  logic [DW-1:0] data_a;
  int            base_v;

  initial begin
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("reset_busy",  {31'd0, busy_out},      32'd0);
    chk("reset_data",  {24'd0, rxdata_out},    32'd0);
    chk("reset_valid", {31'd0, rx_valid_out},  32'd0);
    chk("reset_ferr",  {31'd0, frame_err_out}, 32'd0);
    @(posedge clk_in);
    #1;
    hold(1'b1, 20);

    // Single frame.
    send_frame(8'hA5, 1'b1, P);
    hold(1'b1, P);
    chk("a5_count", n_valid, 1);
    chk("a5_data",  {24'd0, rxdata_out}, 32'h0000_00A5);
    chk("a5_ferr",  n_ferr, 0);

    // Back-to-back frames with a one-bit stop gap.
    send_frame(8'h00, 1'b1, P);
    send_frame(8'hFF, 1'b1, P);
    hold(1'b1, P);
    chk("b2b_count", n_valid, 3);
    chk("b2b_first", {24'd0, got_q[1]}, 32'h0000_0000);
    chk("b2b_second", {24'd0, got_q[2]}, 32'h0000_00FF);

    // Short low pulse: rejected at the mid-start check.
    hold(1'b0, 20);
    hold(1'b1, 2 * P);
    chk("glitch_count", n_valid, 3);
    chk("glitch_ferr",  n_ferr, 0);

    // Low stop bit with the line parked low: one error, data kept, no retrigger.
    send_frame(8'h55, 1'b0, P);
    hold(1'b0, 2 * P);
    hold(1'b1, 2 * P);
    chk("ferr_count", n_ferr, 1);
    chk("ferr_valid", n_valid, 3);
    chk("ferr_data",  {24'd0, rxdata_out}, 32'h0000_00FF);

    // Reset in the middle of data bit 4 (bit 4 of 8'h96 is 1).
    data_a = 8'h96;
    hold(1'b0, P);
    for (int i = 0; i < 4; i++) hold(data_a[i], P);
    hold(data_a[4], P / 2);
    pulse_reset();
    @(negedge clk_in);
    chk("mid_rst_busy",  {31'd0, busy_out},      32'd0);
    chk("mid_rst_data",  {24'd0, rxdata_out},    32'd0);
    chk("mid_rst_valid", {31'd0, rx_valid_out},  32'd0);
    chk("mid_rst_ferr",  {31'd0, frame_err_out}, 32'd0);
    @(posedge clk_in);
    #1;
    hold(1'b1, 3 * P);
    send_frame(8'h3C, 1'b1, P);
    hold(1'b1, P);
    chk("post_rst_count", n_valid, 4);
    chk("post_rst_data",  {24'd0, rxdata_out}, 32'h0000_003C);

    // Transmitter running 2% slow.
    send_frame(8'hC3, 1'b1, (P * 102) / 100);
    hold(1'b1, P);
    chk("slow_count", n_valid, 5);
    chk("slow_data",  {24'd0, rxdata_out}, 32'h0000_00C3);
    chk("slow_ferr",  n_ferr, 1);

    // Randomized traffic: data, rate skew, stop value, gaps and glitches.
    base_v = n_valid;
    for (int k = 0; k < 25; k++) begin
      rd    = DW'($urandom);
      rstop = ($urandom_range(0, 4) != 0);
      send_frame(rd, rstop, $urandom_range(P - 2, P + 2));
      if (!rstop) hold(1'b1, P);
      hold(1'b1, $urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) begin
        hold(1'b0, $urandom_range(1, H - 5));
        hold(1'b1, 2 * P);
      end
    end
    hold(1'b1, 3 * P);
    chk("random_some_frames", {31'd0, 1'(n_valid > base_v)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
